// File: rtl/image_ram_writer.sv
// image_ram_writer
//
// Stores one frame received over a valid/ready pixel stream into an internal
// RAM at sequential addresses 0..LENGTH-1, and offers a registered
// random-access read port with the same addressing and one-cycle latency as
// the image ROM, so it can stand in for it.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse, begins or restarts a frame at address 0
//   in_valid  source presents a pixel
//   in_data   pixel value
//   in_ready  pixel accepted this cycle when in_valid is also high
//   busy      frame write in progress
//   done      full frame stored, sticky until next start
//   err       sticky: in_valid seen while not writing; cleared by start
//   wr_count  pixels accepted in the current frame
//   r_addr    read address
//   rd        registered read data (0 for out-of-range addresses)
//
// State table:
//   IDLE  | after reset, waiting for start
//   WRITE | accepting pixels into the RAM
//   DONE  | LENGTH pixels stored, waiting for start
//
// The RAM is deliberately not reset so frame contents survive rst_n.

module image_ram_writer #(
    parameter int WIDTH  = 8,
    parameter int LENGTH = 65536
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      wr_count,
    input  logic [31:0]      r_addr,
    output logic [WIDTH-1:0] rd
);

    localparam int          AW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [31:0] LEN  = 32'(LENGTH);
    localparam logic [31:0] LAST = 32'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [WIDTH-1:0] mem [LENGTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready drops combinationally on start so a beat coinciding with a
    // restart never completes a handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WRITE;
            end
            WRITE: begin
                in_ready = !start;
                if (start) begin
                    state_next = WRITE;
                end else if (in_valid && (wr_count == LAST)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) state_next = WRITE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;
    assign busy   = (state == WRITE);
    assign done   = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
        end else if (start) begin
            wr_count <= '0;
        end else if (accept) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    // start wins over a simultaneous error condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (start) begin
            err <= 1'b0;
        end else if (in_valid && (state != WRITE)) begin
            err <= 1'b1;
        end
    end

    // wr_count is always below LENGTH while in WRITE, so the low bits index
    // the RAM directly.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_count[AW-1:0]] <= in_data;
        end
    end

    // Non-blocking read of mem returns pre-write data on a same-address
    // read/write collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd <= '0;
        end else if (r_addr < LEN) begin
            rd <= mem[r_addr[AW-1:0]];
        end else begin
            rd <= '0;
        end
    end

endmodule

// File: tb/tb_image_ram_writer.sv
// tb_image_ram_writer
//
// Directed bench for image_ram_writer. A small LENGTH=16 instance is driven
// step by step against a behavioural model; expected read data is queued when
// an address is driven and compared when rd appears a cycle later. A second
// instance with default parameters writes a full 65536-pixel frame.

module tb_image_ram_writer;

    localparam int W = 8;
    localparam int L = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] wr_count;
    logic [31:0] r_addr = 32'hFFFF_FFFF;
    logic [7:0]  rd;

    logic        b_start = 1'b0;
    logic        b_in_valid = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic        b_in_ready;
    logic        b_busy;
    logic        b_done;
    logic        b_err;
    logic [31:0] b_wr_count;
    logic [31:0] b_r_addr = '0;
    logic [7:0]  b_rd;

    always #5 clk = ~clk;

    image_ram_writer #(.WIDTH(W), .LENGTH(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .busy(busy), .done(done),
        .err(err), .wr_count(wr_count), .r_addr(r_addr), .rd(rd)
    );

    image_ram_writer big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid),
        .in_data(b_in_data), .in_ready(b_in_ready), .busy(b_busy), .done(b_done),
        .err(b_err), .wr_count(b_wr_count), .r_addr(b_r_addr), .rd(b_rd)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0=IDLE 1=WRITE 2=DONE
    int          m_state = 0;
    int          m_cnt = 0;
    logic        m_err = 1'b0;
    logic [7:0]  m_mem [L];
    logic [7:0]  rdq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered and left at a falling edge: drive, check in_ready, clock,
    // then check registered outputs and the queued read result.
    task automatic step(input logic s, input logic v, input logic [7:0] d,
                        input logic [31:0] ra);
        logic exp_ready;
        logic acc;
        start = s; in_valid = v; in_data = d; r_addr = ra;
        #1;
        exp_ready = (m_state == 1) && !s;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = v && exp_ready;
        rdq.push_back((ra < 32'(L)) ? m_mem[ra[3:0]] : 8'h00);
        @(posedge clk);
        if (s) begin
            m_state = 1; m_cnt = 0; m_err = 1'b0;
        end else begin
            if (v && m_state != 1) m_err = 1'b1;
            if (acc) begin
                m_mem[m_cnt] = d;
                m_cnt++;
                if (m_cnt == L) m_state = 2;
            end
        end
        @(negedge clk);
        chk("busy", {31'd0, busy}, {31'd0, m_state == 1});
        chk("done", {31'd0, done}, {31'd0, m_state == 2});
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("wr_count", wr_count, 32'(m_cnt));
        if (rdq.size() == 0) begin
            chk("rd_queue_empty", 32'd0, 32'd1);
        end else begin
            chk("rd", {24'd0, rd}, {24'd0, rdq.pop_front()});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        chk({tag, "_wr_count"}, wr_count, 32'd0);
        chk({tag, "_rd"}, {24'd0, rd}, 32'd0);
    endtask

    initial begin
        int bad;
        // Reset values
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // in_valid while IDLE sets err and writes nothing
        step(1'b0, 1'b1, 8'h99, 32'hFFFF_FFFF);
        chk("idle_err", {31'd0, err}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 32'hFFFF_FFFF);
        // start clears err and raises busy
        step(1'b1, 1'b1, 8'h77, 32'hFFFF_FFFF);
        chk("start_clears_err", {31'd0, err}, 32'd0);
        chk("start_busy", {31'd0, busy}, 32'd1);

        // 16 back-to-back beats, reading each address the cycle after its write
        for (int i = 0; i < L; i++) begin
            step(1'b0, 1'b1, 8'h10 + 8'(i), (i == 0) ? 32'hFFFF_FFFF : 32'(i - 1));
        end
        chk("frame1_done", {31'd0, done}, 32'd1);
        chk("frame1_count", wr_count, 32'd16);
        for (int i = 0; i < L; i++) step(1'b0, 1'b0, 8'h00, 32'(i));
        chk("frame1_rd15", {24'd0, rd}, 32'h1F);

        // Stall pattern 1,0,1,0...
        step(1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF);
        for (int i = 0; i < 40 && m_cnt < L; i++) begin
            step(1'b0, (i % 2) == 0, 8'hA0 + 8'(m_cnt), 32'hFFFF_FFFF);
        end
        chk("stall_done", {31'd0, done}, 32'd1);
        chk("stall_count", wr_count, 32'd16);
        for (int i = 0; i < L; i++) step(1'b0, 1'b0, 8'h00, 32'(i));
        chk("stall_rd15", {24'd0, rd}, 32'hAF);

        // Restart mid-frame; the beat coinciding with start is dropped
        step(1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i), 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 8'hEE, 32'hFFFF_FFFF);
        chk("restart_count", wr_count, 32'd0);
        for (int i = 0; i < L; i++) step(1'b0, 1'b1, 8'h20 + 8'(i), 32'hFFFF_FFFF);
        chk("restart_done", {31'd0, done}, 32'd1);
        step(1'b0, 1'b0, 8'h00, 32'd0);
        chk("restart_rd0", {24'd0, rd}, 32'h20);
        step(1'b0, 1'b0, 8'h00, 32'd16);
        chk("rd_oob16", {24'd0, rd}, 32'h00);
        step(1'b0, 1'b0, 8'h00, 32'hFFFF_FFFF);
        chk("rd_oob_max", {24'd0, rd}, 32'h00);

        // Same-address read/write on address 3, then 7 beats and async reset
        step(1'b1, 1'b0, 8'h00, 32'hFFFF_FFFF);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'h50 + 8'(i), (i == 3 || i == 4) ? 32'd3 : 32'hFFFF_FFFF);
            if (i == 3) chk("rw_same_old", {24'd0, rd}, 32'h23);
            if (i == 4) chk("rw_same_new", {24'd0, rd}, 32'h53);
        end
        r_addr = 32'd2;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset_rd", {24'd0, rd}, 32'h52);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        m_state = 0; m_cnt = 0; m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 32'(i));
        chk("post_reset_rd6", {24'd0, rd}, 32'h56);
        step(1'b0, 1'b1, 8'h66, 32'd7);
        chk("post_reset_rd7_old", {24'd0, rd}, 32'h27);
        chk("post_reset_no_ready", {31'd0, busy}, 32'd0);

        // Full-size frame with default parameters
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 65536; i++) begin
            b_in_data = 8'(i);
            #1;
            if (b_in_ready !== 1'b1 || b_wr_count !== 32'(i) || b_done !== 1'b0) bad++;
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        chk("big_beats", 32'(bad), 32'd0);
        chk("big_done", {31'd0, b_done}, 32'd1);
        chk("big_busy", {31'd0, b_busy}, 32'd0);
        chk("big_count", b_wr_count, 32'd65536);
        chk("big_err", {31'd0, b_err}, 32'd0);
        b_r_addr = 32'd0;
        @(negedge clk);
        chk("big_rd0", {24'd0, b_rd}, 32'h00);
        b_r_addr = 32'd255;
        @(negedge clk);
        chk("big_rd255", {24'd0, b_rd}, 32'hFF);
        b_r_addr = 32'd65535;
        @(negedge clk);
        chk("big_rd65535", {24'd0, b_rd}, 32'hFF);
        b_r_addr = 32'd65536;
        @(negedge clk);
        chk("big_rd_oob", {24'd0, b_rd}, 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
